mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Clock is clk and reset is rst; rst is synchronous, active-high, and sampled on posedge clk.
REQ-002 Parameter TIMEOUT, default 255, is the maximum number of wait cycles for dm_ack (range 1..255).
REQ-003 clk  in  1  pipeline clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in, Zero_in  in  1 each  EX/MEM control and flag fields.
REQ-006 ALU_result_in  in  32  memory address or ALU value.
REQ-007 WriteData_in  in  32  store data.
REQ-008 WriteReg_in  in  5  destination register.
REQ-009 dm_req  out  1  data-memory request, registered.
REQ-010 dm_we  out  1  1 = store, 0 = load; valid while dm_req=1.
REQ-011 dm_addr  out  32  word-aligned byte address.
REQ-012 dm_wdata  out  32  store data.
REQ-013 dm_rdata  in  32  load data, valid when dm_ack=1.
REQ-014 dm_ack  in  1  single-cycle completion pulse.
REQ-015 stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM, combinational.
REQ-016 PCSrc  out  1  taken branch, combinational Branch_in & Zero_in.
REQ-017 MemtoReg_out, RegWrite_out  out  1 each  MEM/WB control fields.
REQ-018 ReadData_out, ALU_result_out  out  32 each  MEM/WB data fields.
REQ-019 WriteReg_out  out  5  MEM/WB destination register.
REQ-020 mem_err  out  1  sticky flag for a misaligned access or timeout.

Function
REQ-021 The FSM SHALL have two states: IDLE and WAIT.
REQ-022 mem_op is defined as MemRead_in | MemWrite_in; if both inputs are 1, the access SHALL be treated as a store.
REQ-023 The FSM SHALL move from IDLE to WAIT when mem_op=1 and ALU_result_in[1:0]=0, and dm_req SHALL rise on that same edge.
REQ-024 In WAIT, dm_req, dm_we, dm_addr and dm_wdata SHALL hold constant until the ack cycle; on dm_ack=1 the FSM SHALL return to IDLE and dm_req SHALL drop on that edge.
REQ-025 stall SHALL equal mem_op & ~(state==WAIT & dm_ack) & ~abort, where abort = misaligned address in IDLE, or the timeout counter reaching TIMEOUT in WAIT.
REQ-026 Latency: the minimum memory operation is 2 cycles (IDLE issue, then WAIT with ack); a non-memory instruction takes 1 cycle.
REQ-027 While stall=1, the MEM/WB outputs SHALL load a bubble: RegWrite_out=0, MemtoReg_out=0, other fields unchanged.
REQ-028 While stall=0, the MEM/WB outputs SHALL register the *_in fields, and ReadData_out SHALL register dm_rdata on a load ack and 0 otherwise.
REQ-029 The timeout counter is 8 bits, clears on entry to WAIT, and increments each WAIT cycle without ack.
REQ-030 On timeout, the FSM SHALL return to IDLE, dm_req SHALL drop, mem_err SHALL set, and a bubble SHALL be written to MEM/WB.
REQ-031 A misaligned access SHALL issue no dm_req, SHALL set mem_err, SHALL write a bubble for one cycle, and SHALL not stall.
REQ-032 If dm_ack and timeout expiry occur in the same cycle, the ack SHALL win.
REQ-033 A dm_ack received in IDLE SHALL be ignored.

Reset
REQ-034 When rst=1, the block SHALL set state=IDLE, dm_req=0, the counter=0 and mem_err=0, and all MEM/WB outputs and dm_* outputs to 0, overriding an outstanding access; stall and PCSrc remain combinational.

Structure
REQ-035 The FSM state encoding and the default TIMEOUT value SHALL be defined in shared package pipeline_pkg.
REQ-036 The MEM/WB register SHALL be a sub-module named memwb_reg with a bubble input; the FSM and counter stay in the top module.

Verification
REQ-037 Load with ALU_result_in=0x10 and dm_ack on the 3rd WAIT cycle, dm_rdata=0xDEADBEEF: stall=1 for 3 cycles, ReadData_out=0xDEADBEEF and RegWrite_out=1 on the next edge.
REQ-038 Store with ALU_result_in=0x20 and WriteData_in=0x1234 with immediate ack: dm_we=1, dm_wdata=0x1234, stall for exactly 1 cycle, RegWrite_out=0.
REQ-039 Load with ALU_result_in=0x13: dm_req never rises, mem_err=1, bubble written, stall=0.
REQ-040 TIMEOUT=4 with no ack: dm_req high for 4 cycles then drops, mem_err=1, FSM back in IDLE.
REQ-041 Assert rst in the 2nd WAIT cycle: dm_req=0 and all outputs 0 on the next edge; a later ack is ignored.
REQ-042 Branch_in=1 with Zero_in=1 and no memory op: PCSrc=1 in the same cycle and stall=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: memory-stage FSM encoding, default ack timeout and MEM/WB record
package pipeline_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int TIMEOUT_DEFAULT = 255;
  typedef struct packed {
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
  } memwb_t;
endpackage

// File: rtl/memwb_reg.sv
// memwb_reg: MEM/WB pipeline register; a bubble clears the write-back controls and keeps the data fields
module memwb_reg
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (bubble) begin
      q.mem_to_reg <= 1'b0;
      q.reg_write <= 1'b0;
    end else q <= d;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage issuing one data-memory access per instruction, stalling the pipe until ack or timeout
module mem_access_unit
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Branch_in,
  input  logic        Zero_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  WriteReg_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        PCSrc,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  WriteReg_out,
  output logic        mem_err
);
  logic [0:0] state;
  logic [7:0] cnt;
  logic mem_op, aligned, issue, misaligned, ack, timeout, abort;
  memwb_t d, q;
  assign mem_op = MemRead_in | MemWrite_in;
  assign aligned = ALU_result_in[1:0] == 2'b00;
  assign issue = state == IDLE && mem_op && aligned;
  assign misaligned = state == IDLE && mem_op && !aligned;
  assign ack = state == WAIT && dm_ack;
  // the last permitted wait cycle ends the access unless an ack arrives in it
  assign timeout = state == WAIT && !dm_ack && cnt == 8'(TIMEOUT - 1);
  assign abort = misaligned | timeout;
  assign stall = mem_op & ~ack & ~abort;
  assign PCSrc = Branch_in & Zero_in;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      mem_err <= 1'b0;
      dm_req <= 1'b0;
      dm_we <= 1'b0;
      dm_addr <= '0;
      dm_wdata <= '0;
    end else begin
      if (issue) begin
        state <= WAIT;
        cnt <= '0;
        dm_req <= 1'b1;
        dm_we <= MemWrite_in;
        dm_addr <= ALU_result_in;
        dm_wdata <= WriteData_in;
      end else if (state == WAIT) begin
        if (dm_ack || timeout) begin
          state <= IDLE;
          dm_req <= 1'b0;
        end else cnt <= cnt + 8'd1;
      end
      if (abort) mem_err <= 1'b1;
    end
  assign d = '{
    mem_to_reg: MemtoReg_in,
    reg_write:  RegWrite_in,
    read_data:  (ack && MemRead_in && !MemWrite_in) ? dm_rdata : 32'h0,
    alu_result: ALU_result_in,
    write_reg:  WriteReg_in
  };
  memwb_reg u_memwb (
    .clk(clk),
    .rst(rst),
    .bubble(stall | abort),
    .d(d),
    .q(q)
  );
  assign MemtoReg_out = q.mem_to_reg;
  assign RegWrite_out = q.reg_write;
  assign ReadData_out = q.read_data;
  assign ALU_result_out = q.alu_result;
  assign WriteReg_out = q.write_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, reset-during-wait sequence and random instructions against a transaction-level model
module tb_mem_access_unit;
  localparam int TO = 4;
  typedef struct packed {
    logic mr, mw, mtr, rw, br, zr;
    logic [31:0] addr, wd, rd;
    logic [4:0] wr;
    logic [3:0] ack_at;
    logic rst_before;
  } vec_t;
  typedef struct packed {
    logic [3:0] stall, req;
    logic mtr, rw;
    logic [31:0] rd, alu;
    logic [4:0] wr;
    logic err;
  } exp_t;
  logic clk, rst;
  logic MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in, Zero_in;
  logic [31:0] ALU_result_in, WriteData_in, dm_rdata;
  logic [4:0] WriteReg_in;
  logic dm_ack;
  logic dm_req, dm_we, stall, PCSrc, MemtoReg_out, RegWrite_out, mem_err;
  logic [31:0] dm_addr, dm_wdata, ReadData_out, ALU_result_out;
  logic [4:0] WriteReg_out;
  int errors = 0, checks = 0;
  vec_t tv [9];
  exp_t te [9];
  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .Branch_in(Branch_in), .Zero_in(Zero_in),
    .ALU_result_in(ALU_result_in), .WriteData_in(WriteData_in), .WriteReg_in(WriteReg_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall), .PCSrc(PCSrc),
    .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .ReadData_out(ReadData_out),
    .ALU_result_out(ALU_result_out), .WriteReg_out(WriteReg_out), .mem_err(mem_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    MemRead_in = v.mr; MemWrite_in = v.mw; MemtoReg_in = v.mtr; RegWrite_in = v.rw;
    Branch_in = v.br; Zero_in = v.zr; ALU_result_in = v.addr; WriteData_in = v.wd; WriteReg_in = v.wr;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    dm_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  // One instruction: stays on the inputs for req+1 cycles (issue plus every wait cycle)
  task automatic apply(input vec_t v, input exp_t e, input string tag);
    int n_stall, n_req, bad_pc, bad_dm;
    n_stall = 0; n_req = 0; bad_pc = 0; bad_dm = 0;
    if (v.rst_before) do_reset();
    drive(v);
    for (int c = 0; c <= int'(e.req); c++) begin
      dm_ack = (c == 0) ? ($urandom_range(0, 3) == 0) : (c == int'(v.ack_at));
      dm_rdata = (c > 0 && c == int'(v.ack_at)) ? v.rd : $urandom;
      @(negedge clk);
      n_stall += int'(stall);
      n_req += int'(dm_req);
      if (PCSrc !== (v.br & v.zr)) bad_pc++;
      if (dm_req && (dm_we !== v.mw || dm_addr !== v.addr || dm_wdata !== v.wd)) bad_dm++;
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
    chk({tag, ".stall_cycles"}, n_stall, 32'(e.stall));
    chk({tag, ".req_cycles"}, n_req, 32'(e.req));
    chk({tag, ".pcsrc_bad"}, bad_pc, 0);
    chk({tag, ".dm_fields_bad"}, bad_dm, 0);
    chk({tag, ".dm_req_after"}, dm_req, 0);
    chk({tag, ".MemtoReg_out"}, MemtoReg_out, e.mtr);
    chk({tag, ".RegWrite_out"}, RegWrite_out, e.rw);
    chk({tag, ".ReadData_out"}, ReadData_out, e.rd);
    chk({tag, ".ALU_result_out"}, ALU_result_out, e.alu);
    chk({tag, ".WriteReg_out"}, WriteReg_out, e.wr);
    chk({tag, ".mem_err"}, mem_err, e.err);
  endtask
  // Outcome of one instruction from the access rules: k wait cycles on an ack in wait cycle k<=TO, TO on timeout
  function automatic exp_t predict(input vec_t v, input exp_t m);
    exp_t e;
    logic memop, misal, acked;
    e = m;
    memop = v.mr | v.mw;
    misal = memop && v.addr[1:0] != 2'b00;
    acked = memop && !misal && int'(v.ack_at) <= TO;
    e.stall = (memop && !misal) ? (acked ? v.ack_at : 4'(TO)) : 4'd0;
    e.req = e.stall;
    if (misal || (memop && !acked)) begin
      e.mtr = 1'b0; e.rw = 1'b0; e.err = 1'b1;
    end else begin
      e.mtr = v.mtr; e.rw = v.rw; e.alu = v.addr; e.wr = v.wr;
      e.rd = (acked && !v.mw) ? v.rd : 32'h0;
    end
    return e;
  endfunction
  initial begin
    vec_t v;
    exp_t e, m;
    int kind;
    // mr mw mtr rw br zr addr wd rd wr ack_at rst_before
    tv[0] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h55, 32'h0, 32'h0, 5'd3, 4'd1, 1'b0};
    tv[1] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h8, 32'h0, 32'h0, 5'd0, 4'd1, 1'b0};
    tv[2] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 5'd7, 4'd3, 1'b0};
    tv[3] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 32'h20, 32'h1234, 32'h5555, 5'd9, 4'd1, 1'b0};
    tv[4] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h24, 32'hABCD, 32'h1111, 5'd2, 4'd2, 1'b0};
    tv[5] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 32'h10, 32'h0, 32'hCAFEF00D, 5'd4, 4'd4, 1'b0};
    tv[6] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h40, 32'h0, 32'h0, 5'd6, 4'd5, 1'b0};
    tv[7] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h13, 32'h0, 32'h0, 5'd5, 4'd1, 1'b1};
    tv[8] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 32'h22, 32'h9, 32'h0, 5'd8, 4'd1, 1'b0};
    // stall req mtr rw rd alu wr err
    te[0] = '{4'd0, 4'd0, 1'b0, 1'b1, 32'h0, 32'h55, 5'd3, 1'b0};
    te[1] = '{4'd0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h8, 5'd0, 1'b0};
    te[2] = '{4'd3, 4'd3, 1'b1, 1'b1, 32'hDEADBEEF, 32'h10, 5'd7, 1'b0};
    te[3] = '{4'd1, 4'd1, 1'b0, 1'b0, 32'h0, 32'h20, 5'd9, 1'b0};
    te[4] = '{4'd2, 4'd2, 1'b0, 1'b0, 32'h0, 32'h24, 5'd2, 1'b0};
    te[5] = '{4'd4, 4'd4, 1'b1, 1'b1, 32'hCAFEF00D, 32'h10, 5'd4, 1'b0};
    te[6] = '{4'd4, 4'd4, 1'b0, 1'b0, 32'hCAFEF00D, 32'h10, 5'd4, 1'b1};
    te[7] = '{4'd0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1};
    te[8] = '{4'd0, 4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1};
    rst = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    drive('0);
    do_reset();
    chk("reset.dm_req", dm_req, 0);
    chk("reset.dm_we", dm_we, 0);
    chk("reset.dm_addr", dm_addr, 0);
    chk("reset.dm_wdata", dm_wdata, 0);
    chk("reset.RegWrite_out", RegWrite_out, 0);
    chk("reset.ReadData_out", ReadData_out, 0);
    chk("reset.mem_err", mem_err, 0);
    chk("reset.stall", stall, 0);
    for (int i = 0; i < 9; i++) apply(tv[i], te[i], $sformatf("vec%0d", i));
    // reset landing in the second wait cycle, then a stray ack in IDLE
    do_reset();
    v = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0, 32'h30, 32'h77, 32'h0, 5'd12, 4'd0, 1'b0};
    drive(v);
    @(posedge clk); #1;
    chk("rstwait.dm_req_wait1", dm_req, 1);
    @(negedge clk);
    chk("rstwait.stall_wait1", stall, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive('0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstwait.dm_req", dm_req, 0);
    chk("rstwait.dm_we", dm_we, 0);
    chk("rstwait.dm_addr", dm_addr, 0);
    chk("rstwait.dm_wdata", dm_wdata, 0);
    chk("rstwait.MemtoReg_out", MemtoReg_out, 0);
    chk("rstwait.RegWrite_out", RegWrite_out, 0);
    chk("rstwait.ALU_result_out", ALU_result_out, 0);
    chk("rstwait.WriteReg_out", WriteReg_out, 0);
    chk("rstwait.mem_err", mem_err, 0);
    v = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h99, 32'h0, 32'h0, 5'd11, 4'd0, 1'b0};
    drive(v);
    dm_ack = 1'b1; dm_rdata = 32'hFFFF;
    @(negedge clk);
    chk("idleack.stall", stall, 0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    chk("idleack.dm_req", dm_req, 0);
    chk("idleack.ReadData_out", ReadData_out, 0);
    chk("idleack.RegWrite_out", RegWrite_out, 1);
    chk("idleack.WriteReg_out", WriteReg_out, 11);
    do_reset();
    m = '0;
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 3);
      v.mr = kind == 1 || kind == 3;
      v.mw = kind >= 2;
      v.mtr = 1'($urandom); v.rw = 1'($urandom); v.br = 1'($urandom); v.zr = 1'($urandom);
      v.addr = $urandom & ~32'h3;
      if ($urandom_range(0, 5) == 0) v.addr[1:0] = 2'($urandom_range(1, 3));
      v.wd = $urandom; v.rd = $urandom; v.wr = 5'($urandom);
      v.ack_at = 4'($urandom_range(1, TO + 1));
      v.rst_before = m.err && $urandom_range(0, 1) == 1;
      if (v.rst_before) m = '0;
      e = predict(v, m);
      apply(v, e, $sformatf("rand%0d", i));
      m = e;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
